// File: rtl/parking_pkg.sv
// Shared types and sensor-pattern constants for the parking-lot blocks.
// ab_pattern() maps a direction and phase onto the {A,B} value driven in that phase.
package parking_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PH1  = 3'd1,
      PH2  = 3'd2,
      PH3  = 3'd3,
      GAP  = 3'd4,
      DONE = 3'd5
   } seq_state_t;

   localparam logic [1:0] AB_ENTER_PH1 = 2'b10;
   localparam logic [1:0] AB_ENTER_PH2 = 2'b11;
   localparam logic [1:0] AB_ENTER_PH3 = 2'b01;
   localparam logic [1:0] AB_EXIT_PH1  = 2'b01;
   localparam logic [1:0] AB_EXIT_PH2  = 2'b11;
   localparam logic [1:0] AB_EXIT_PH3  = 2'b10;
   localparam logic [1:0] AB_CLEAR     = 2'b00;
   localparam logic [3:0] MAX_CARS     = 4'd15;

   function automatic logic [1:0] ab_pattern(input logic is_exit, input seq_state_t ph);
      logic [1:0] p;
      p = AB_CLEAR;
      case (ph)
         PH1:     p = is_exit ? AB_EXIT_PH1 : AB_ENTER_PH1;
         PH2:     p = is_exit ? AB_EXIT_PH2 : AB_ENTER_PH2;
         PH3:     p = is_exit ? AB_EXIT_PH3 : AB_ENTER_PH3;
         default: p = AB_CLEAR;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/sensor_seq_gen_if.sv
// Request / sensor-output bundle of the sensor sequence generator.
interface sensor_seq_gen_if #(
   parameter int HOLD_W = 4
);
   logic              enter_req;
   logic              exit_req;
   logic [HOLD_W-1:0] hold;
   logic              A;
   logic              B;
   logic              busy;
   logic              done;
   logic              reject;
   logic [3:0]        occupancy;

   modport master (
      output enter_req, exit_req, hold,
      input  A, B, busy, done, reject, occupancy
   );

   modport slave (
      input  enter_req, exit_req, hold,
      output A, B, busy, done, reject, occupancy
   );
endinterface

// File: rtl/sensor_seq_gen_phase_timer.sv
// Per-phase down-counter: start loads and remembers the hold count, expire flags the
// last cycle of a phase and the count reloads itself for the following phase.
module phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] load_val,
   input  logic         run,
   output logic         expire
);
   logic [W-1:0] cnt;
   logic [W-1:0] reload;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         reload <= '0;
      end else if (start) begin
         cnt    <= load_val;
         reload <= load_val;
      end else if (run) begin
         if (cnt == '0) cnt <= reload;
         else           cnt <= cnt - 1'b1;
      end
   end

   // Counting hold..0 gives hold+1 cycles per phase without needing an extra bit.
   assign expire = run && (cnt == '0);
endmodule

// File: rtl/sensor_seq_gen.sv
// Parking-lot sensor stimulus generator: plays one car entry/exit {A,B} pattern per
// accepted request and keeps a model car count.
//
// state | meaning
// IDLE  | waiting; requests sampled here only
// PH1   | first sensor phase
// PH2   | both sensors covered
// PH3   | last sensor phase
// GAP   | both sensors clear
// DONE  | one-cycle completion, occupancy updated
module sensor_seq_gen
   import parking_pkg::*;
#(
   parameter int HOLD_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   sensor_seq_gen_if.slave bus
);
   seq_state_t state;
   logic       dir_exit;
   logic [1:0] ab;
   logic [3:0] occ;
   logic       busy_r, done_r, reject_r;
   logic       legal_enter, legal_exit, accept, refuse, timer_run, expire;

   always_comb begin
      legal_enter = bus.enter_req && (occ != MAX_CARS);
      legal_exit  = bus.exit_req && (occ != 4'd0);
      accept      = 1'b0;
      refuse      = 1'b0;
      if (state == IDLE) begin
         // enter has priority; a simultaneous exit is dropped even when enter is refused
         accept = bus.enter_req ? legal_enter : legal_exit;
         refuse = bus.enter_req ? !legal_enter : (bus.exit_req && !legal_exit);
      end
      timer_run = (state == PH1) || (state == PH2) || (state == PH3) || (state == GAP);
   end

   phase_timer #(.W(HOLD_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .start    (accept),
      .load_val (bus.hold),
      .run      (timer_run),
      .expire   (expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         dir_exit <= 1'b0;
         ab       <= AB_CLEAR;
         occ      <= 4'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         reject_r <= 1'b0;
      end else begin
         done_r   <= 1'b0;
         reject_r <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= PH1;
                  dir_exit <= !bus.enter_req;
                  ab       <= ab_pattern(!bus.enter_req, PH1);
                  busy_r   <= 1'b1;
               end else if (refuse) begin
                  reject_r <= 1'b1;
               end
            end
            PH1: if (expire) begin
               state <= PH2;
               ab    <= ab_pattern(dir_exit, PH2);
            end
            PH2: if (expire) begin
               state <= PH3;
               ab    <= ab_pattern(dir_exit, PH3);
            end
            PH3: if (expire) begin
               state <= GAP;
               ab    <= AB_CLEAR;
            end
            GAP: if (expire) begin
               state  <= DONE;
               done_r <= 1'b1;
               occ    <= dir_exit ? occ - 4'd1 : occ + 4'd1;
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               ab     <= AB_CLEAR;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.A         = ab[1];
   assign bus.B         = ab[0];
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.reject    = reject_r;
   assign bus.occupancy = occ;
endmodule

// File: tb/tb_sensor_seq_gen.sv
// Self-checking bench for sensor_seq_gen: vector table, hand-written corner sequences and a
// random request stream checked against a phase-list model and an A/B pattern decoder.
module tb_sensor_seq_gen;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   int   occ_model;
   int   dec_cnt;
   logic [1:0] prev_ab;
   logic [1:0] seen[$];

   sensor_seq_gen_if #(.HOLD_W(4)) bus ();

   sensor_seq_gen #(.HOLD_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Decoder: counts a car when the sensors step through a complete pattern and then clear.
   always @(negedge clk) begin
      logic [1:0] cur;
      if (reset) begin
         seen.delete();
         dec_cnt = 0;
         prev_ab = 2'b00;
      end else begin
         cur = {bus.A, bus.B};
         if (cur != prev_ab) begin
            if (cur == 2'b00) begin
               if (seen.size() == 3 && seen[0] == 2'b10 && seen[1] == 2'b11 && seen[2] == 2'b01)
                  dec_cnt++;
               else if (seen.size() == 3 && seen[0] == 2'b01 && seen[1] == 2'b11 && seen[2] == 2'b10)
                  dec_cnt--;
               seen.delete();
            end else begin
               seen.push_back(cur);
            end
         end
         prev_ab = cur;
      end
   end

   // Called at a negedge while the DUT is idle; returns at the negedge of the first idle cycle.
   task automatic seq_check(input bit en, input bit ex, input int h, input bit jitter,
                            output bit rej_seen);
      bit         is_exit, legal;
      int         n;
      logic [1:0] pat[4];
      logic [1:0] exp_ab[$];
      rej_seen = 1'b0;
      if (!en && !ex) begin
         @(negedge clk);
         return;
      end
      is_exit = !en;
      legal   = en ? (occ_model < 15) : (occ_model > 0);
      if (is_exit) pat = '{2'b01, 2'b11, 2'b10, 2'b00};
      else         pat = '{2'b10, 2'b11, 2'b01, 2'b00};
      n = h + 1;
      for (int p = 0; p < 4; p++)
         for (int k = 0; k < n; k++) exp_ab.push_back(pat[p]);

      bus.enter_req = en;
      bus.exit_req  = ex;
      bus.hold      = 4'(h);
      @(posedge clk);
      @(negedge clk);
      bus.enter_req = 1'b0;
      bus.exit_req  = 1'b0;
      rej_seen = bus.reject;

      if (!legal) begin
         check("reject_pulse", 32'(bus.reject), 1);
         check("reject_busy", 32'(bus.busy), 0);
         check("reject_ab", 32'({bus.A, bus.B}), 0);
         check("reject_occ", 32'(bus.occupancy), occ_model);
         @(negedge clk);
         check("reject_width", 32'(bus.reject), 0);
         check("reject_busy2", 32'(bus.busy), 0);
         return;
      end

      check("accept_no_reject", 32'(bus.reject), 0);
      for (int k = 0; k < 4 * n; k++) begin
         check("ab", 32'({bus.A, bus.B}), 32'(exp_ab[k]));
         check("busy", 32'(bus.busy), 1);
         check("done_early", 32'(bus.done), 0);
         if (jitter) bus.hold = 4'($urandom);
         @(negedge clk);
      end
      occ_model = is_exit ? occ_model - 1 : occ_model + 1;
      check("done", 32'(bus.done), 1);
      check("done_busy", 32'(bus.busy), 1);
      check("occ", 32'(bus.occupancy), occ_model);
      check("decoder", dec_cnt, 32'(bus.occupancy));
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_done", 32'(bus.done), 0);
   endtask

   typedef struct {
      bit en;
      bit ex;
      int h;
      bit exp_rej;
      int exp_occ;
   } vec_t;

   vec_t tbl[10];

   initial begin
      bit rej;
      bit en;
      n_cmp = 0;
      n_bad = 0;
      occ_model = 0;

      tbl[0] = '{en: 0, ex: 1, h: 0,  exp_rej: 1, exp_occ: 0};
      tbl[1] = '{en: 1, ex: 0, h: 0,  exp_rej: 0, exp_occ: 1};
      tbl[2] = '{en: 1, ex: 0, h: 0,  exp_rej: 0, exp_occ: 2};
      tbl[3] = '{en: 0, ex: 1, h: 0,  exp_rej: 0, exp_occ: 1};
      tbl[4] = '{en: 1, ex: 0, h: 1,  exp_rej: 0, exp_occ: 2};
      tbl[5] = '{en: 1, ex: 1, h: 2,  exp_rej: 0, exp_occ: 3};
      tbl[6] = '{en: 0, ex: 1, h: 15, exp_rej: 0, exp_occ: 2};
      tbl[7] = '{en: 0, ex: 1, h: 3,  exp_rej: 0, exp_occ: 1};
      tbl[8] = '{en: 0, ex: 1, h: 0,  exp_rej: 0, exp_occ: 0};
      tbl[9] = '{en: 0, ex: 1, h: 7,  exp_rej: 1, exp_occ: 0};

      reset = 1'b1;
      bus.enter_req = 1'b0;
      bus.exit_req  = 1'b0;
      bus.hold      = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_ab", 32'({bus.A, bus.B}), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_reject", 32'(bus.reject), 0);
      check("rst_occ", 32'(bus.occupancy), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         seq_check(tbl[i].en, tbl[i].ex, tbl[i].h, 1'b0, rej);
         check("tbl_reject", 32'(rej), 32'(tbl[i].exp_rej));
         check("tbl_occ", 32'(bus.occupancy), tbl[i].exp_occ);
      end

      // Request held high: second sequence starts after exactly one idle cycle.
      bus.enter_req = 1'b1;
      bus.hold      = 4'd0;
      @(posedge clk);
      @(negedge clk);
      check("b2b_ph1", 32'({bus.A, bus.B}), 2);
      repeat (4) @(negedge clk);
      occ_model++;
      check("b2b_done1", 32'(bus.done), 1);
      check("b2b_occ1", 32'(bus.occupancy), occ_model);
      @(negedge clk);
      check("b2b_gap_idle", 32'(bus.busy), 0);
      @(negedge clk);
      check("b2b_restart_busy", 32'(bus.busy), 1);
      check("b2b_restart_ab", 32'({bus.A, bus.B}), 2);
      bus.enter_req = 1'b0;
      repeat (4) @(negedge clk);
      occ_model++;
      check("b2b_done2", 32'(bus.done), 1);
      check("b2b_occ2", 32'(bus.occupancy), occ_model);
      @(negedge clk);

      // Fill to the limit, then both requests together: enter wins and is refused.
      while (occ_model < 15) seq_check(1'b1, 1'b0, 0, 1'b0, rej);
      check("full_occ", 32'(bus.occupancy), 15);
      seq_check(1'b1, 1'b1, 0, 1'b0, rej);
      check("full_prio_reject", 32'(rej), 1);
      check("full_prio_occ", 32'(bus.occupancy), 15);

      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 3);
         seq_check(r[0], r[1], $urandom_range(0, 7), 1'b1, rej);
      end

      // Reset during PH2 of a hold=3 sequence.
      if (occ_model == 0) seq_check(1'b1, 1'b0, 0, 1'b0, rej);
      en = (occ_model < 15);
      bus.enter_req = en;
      bus.exit_req  = !en;
      bus.hold      = 4'd3;
      @(posedge clk);
      @(negedge clk);
      bus.enter_req = 1'b0;
      bus.exit_req  = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_ph2_ab", 32'({bus.A, bus.B}), 3);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_ab", 32'({bus.A, bus.B}), 0);
      check("mid_rst_occ", 32'(bus.occupancy), 0);
      check("mid_rst_busy", 32'(bus.busy), 0);
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_no_done", 32'(bus.done), 0);
      end
      occ_model = 0;
      bus.enter_req = 1'b1;
      bus.hold      = 4'd0;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_accept", 32'(bus.busy), 1);
      check("post_rst_ab", 32'({bus.A, bus.B}), 2);
      bus.enter_req = 1'b0;
      repeat (4) @(negedge clk);
      occ_model++;
      check("post_rst_done", 32'(bus.done), 1);
      check("post_rst_occ", 32'(bus.occupancy), occ_model);
      check("post_rst_decoder", dec_cnt, 32'(bus.occupancy));
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sensor_seq_gen.md
SENSOR_SEQ_GEN -- requirements
Module: sensor_seq_gen

Interface
REQ-001 The block SHALL have one parameter: HOLD_W, default 4, width of the per-phase hold-count input.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-004 The block SHALL have port enter_req, input, 1 bit: request to emit one car-entry sensor sequence.
REQ-005 The block SHALL have port exit_req, input, 1 bit: request to emit one car-exit sensor sequence.
REQ-006 The block SHALL have port hold, input, HOLD_W bits: each phase lasts N = hold+1 cycles.
REQ-007 The block SHALL have port A, output, 1 bit: emulated outer sensor.
REQ-008 The block SHALL have port B, output, 1 bit: emulated inner sensor.
REQ-009 The block SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-011 The block SHALL have port reject, output, 1 bit: one-cycle pulse when a request is refused.
REQ-012 The block SHALL have port occupancy, output, 4 bits: model car count, range 0..15.

Function
REQ-013 The FSM SHALL have these states: IDLE, PH1, PH2, PH3, GAP, DONE.
REQ-014 Requests SHALL be sampled only in IDLE; enter_req and exit_req SHALL be ignored in every other state.
REQ-015 When both requests are high in IDLE, enter_req SHALL win and exit_req SHALL be dropped.
REQ-016 A request SHALL be accepted only if it is legal (enter: occupancy<15; exit: occupancy>0); hold and direction SHALL be latched at the accept edge.
REQ-017 An illegal request SHALL pulse reject for the one cycle after the sampling edge, and the FSM SHALL stay in IDLE with occupancy unchanged.
REQ-018 The enter pattern {A,B} SHALL be PH1=10, PH2=11, PH3=01, GAP=00.
REQ-019 The exit pattern {A,B} SHALL be PH1=01, PH2=11, PH3=10, GAP=00.
REQ-020 With the accept at edge 0, PH1 SHALL occupy cycles 1..N, PH2 cycles N+1..2N, PH3 cycles 2N+1..3N, GAP cycles 3N+1..4N, DONE cycle 4N+1, and IDLE from 4N+2.
REQ-021 A and B SHALL be registered outputs, glitch-free, and SHALL change only at phase boundaries.
REQ-022 busy SHALL be high from PH1 through DONE inclusive, and low in IDLE.
REQ-023 done SHALL be high only in the DONE cycle.
REQ-024 occupancy SHALL take its new value (+1 for enter, -1 for exit) in the DONE cycle.
REQ-025 occupancy SHALL never wrap; the legality check of REQ-016 is the only guard against wrap.
REQ-026 A change of hold during a sequence SHALL have no effect until the next accept.
REQ-027 hold=0 SHALL give N=1, minimum sequence latency 5 cycles accept-to-done.
REQ-028 hold=all-ones SHALL give N=2^HOLD_W, with no counter overflow.
REQ-029 A request held high continuously SHALL be re-accepted in the first IDLE cycle after DONE, giving back-to-back sequences separated by one IDLE cycle.

Reset
REQ-030 While reset is high the block SHALL be in state IDLE with A=0, B=0, busy=0, done=0, reject=0, occupancy=0, and the phase counter at 0.
REQ-031 Assertion of reset mid-sequence SHALL force {A,B}=00 immediately without waiting for a clock edge; the partial sequence SHALL be discarded and no done SHALL be emitted.
REQ-032 Requests SHALL be first sampled on the first rising edge after reset deasserts.

Structure
REQ-033 Shared package parking_pkg SHALL hold: the state enum, the constants AB_ENTER_PH1..PH3 and AB_EXIT_PH1..PH3 (2-bit), AB_CLEAR=2'b00, and MAX_CARS=15.
REQ-034 The count sequence SHALL match the one the parking-lot counter in this codebase decodes.
REQ-035 The block SHALL contain one sub-module, phase_timer: it loads hold, counts down, and pulses expire when a phase ends.
REQ-036 The FSM and the occupancy register SHALL be in sensor_seq_gen.

Verification
REQ-037 Scenario, single enter: reset, hold=1, enter_req for 1 cycle -> {A,B} = 10,10,11,11,01,01,00,00; done at cycle 9; occupancy=1.
REQ-038 Scenario, enter then exit: two enters then one exit, hold=0 -> exit pattern 01,11,10,00; final occupancy=1; reject never pulses.
REQ-039 Scenario, empty guard: exit_req at occupancy=0 -> reject pulses 1 cycle; busy stays 0; A=B=0.
REQ-040 Scenario, full guard plus priority: 15 enters, then enter_req and exit_req together -> reject pulses 1 cycle; occupancy stays 15.
REQ-041 Scenario, reset mid-sequence: reset asserted during PH2 -> A=B=0 and occupancy=0 asynchronously; no done.
REQ-042 Scenario, decoder loopback: A and B fed to the parking-lot counter, random enter/exit stream -> counter output equals occupancy after every done.
